// File: rtl/writeback_queue.sv
// writeback_queue: merges single-cycle ALU results and in-order load
// responses into one registered register-file write port, tracks which
// registers await load data (scoreboard) and flags ALU writes to them.
//
// Optional feature: define WB_BYPASS_EN to enable the write-port bypass
// outputs (fwd1/fwd2 and their hit flags); otherwise they are tied to 0.
//
// Ports:
//   CLK, RST                      rising-edge clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data     ALU result to retire (highest priority)
//   ld_req/ld_rd, ld_req_ready    load issue reserving ld_rd; tag FIFO not full
//   ld_resp_valid/ld_resp_data    in-order load data; ld_resp_ready = accepted
//   readReg1/readReg2, stall      decode sources; stall on a pending load
//   writeReg/writeData/RegWrite   registered register-file write port
//   busy                          scoreboard, bit n = xn awaiting load data
//   waw_err                       sticky: ALU wrote a busy register
//   fwd1/fwd2, fwd1_hit/fwd2_hit  bypass of the current write port
module writeback_queue #(
    parameter int unsigned LQ_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_req,
    input  logic [4:0]  ld_rd,
    output logic        ld_req_ready,
    input  logic        ld_resp_valid,
    input  logic [31:0] ld_resp_data,
    output logic        ld_resp_ready,
    input  logic [4:0]  readReg1,
    input  logic [4:0]  readReg2,
    output logic        stall,
    output logic [4:0]  writeReg,
    output logic [31:0] writeData,
    output logic        RegWrite,
    output logic [31:0] busy,
    output logic        waw_err,
    output logic [31:0] fwd1,
    output logic [31:0] fwd2,
    output logic        fwd1_hit,
    output logic        fwd2_hit
);

    localparam int unsigned PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    // Load-tag FIFO
    logic [4:0]    fifo_mem [LQ_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    // One-entry hold register for accepted load data
    logic          hold_valid;
    logic [4:0]    hold_rd;
    logic [31:0]   hold_data;

    logic          push;
    logic          accept;
    logic          drain;
    logic          sel_valid;
    logic [4:0]    sel_rd;
    logic [31:0]   sel_data;
    logic [31:0]   busy_nxt;

    assign full          = (count == CW'(LQ_DEPTH));
    assign empty         = (count == '0);
    assign ld_req_ready  = !full;
    assign ld_resp_ready = !empty && !hold_valid;

    assign push   = ld_req && !full;
    assign accept = ld_resp_valid && ld_resp_ready;
    // Hold drains only when the ALU leaves the write port free
    assign drain  = hold_valid && !alu_valid;

    // Write-port selection: ALU first, then the hold register
    assign sel_valid = alu_valid || hold_valid;
    assign sel_rd    = alu_valid ? alu_rd   : hold_rd;
    assign sel_data  = alu_valid ? alu_data : hold_data;

    assign stall = ((readReg1 != 5'd0) && busy[readReg1]) ||
                   ((readReg2 != 5'd0) && busy[readReg2]);

    // Scoreboard update: a clear from drain, then a set from push so the set wins
    always_comb begin
        busy_nxt = busy;
        if (drain && (hold_rd != 5'd0)) begin
            busy_nxt[hold_rd] = 1'b0;
        end
        if (push && (ld_rd != 5'd0)) begin
            busy_nxt[ld_rd] = 1'b1;
        end
    end

    // FIFO storage (data only, no reset needed)
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= ld_rd;
        end
    end

    // Control state, hold register, scoreboard and registered write port
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            hold_valid <= 1'b0;
            hold_rd    <= '0;
            hold_data  <= '0;
            busy       <= '0;
            waw_err    <= 1'b0;
            RegWrite   <= 1'b0;
            writeReg   <= '0;
            writeData  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (accept) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, accept})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // accept requires an empty hold, so it never collides with drain
            if (accept) begin
                hold_valid <= 1'b1;
                hold_rd    <= fifo_mem[rd_ptr];
                hold_data  <= ld_resp_data;
            end else if (drain) begin
                hold_valid <= 1'b0;
            end

            busy <= busy_nxt;

            if (alu_valid && (alu_rd != 5'd0) && busy[alu_rd]) begin
                waw_err <= 1'b1;
            end

            // x0 writes (ALU or drained hold entry) are dropped here
            RegWrite <= sel_valid && (sel_rd != 5'd0);
            if (sel_valid && (sel_rd != 5'd0)) begin
                writeReg  <= sel_rd;
                writeData <= sel_data;
            end
        end
    end

`ifdef WB_BYPASS_EN
    assign fwd1_hit = RegWrite && (writeReg == readReg1) && (writeReg != 5'd0);
    assign fwd2_hit = RegWrite && (writeReg == readReg2) && (writeReg != 5'd0);
    assign fwd1     = writeData;
    assign fwd2     = writeData;
`else
    assign fwd1_hit = 1'b0;
    assign fwd2_hit = 1'b0;
    assign fwd1     = '0;
    assign fwd2     = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue (LQ_DEPTH = 4).
module tb_writeback_queue;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        CLK;
    logic        RST;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_req;
    logic [4:0]  ld_rd;
    logic        ld_req_ready;
    logic        ld_resp_valid;
    logic [31:0] ld_resp_data;
    logic        ld_resp_ready;
    logic [4:0]  readReg1;
    logic [4:0]  readReg2;
    logic        stall;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        RegWrite;
    logic [31:0] busy;
    logic        waw_err;
    logic [31:0] fwd1;
    logic [31:0] fwd2;
    logic        fwd1_hit;
    logic        fwd2_hit;

    int checks = 0;
    int errors = 0;

    writeback_queue #(.LQ_DEPTH(4)) dut (
        .CLK(CLK), .RST(RST),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_req(ld_req), .ld_rd(ld_rd), .ld_req_ready(ld_req_ready),
        .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
        .ld_resp_ready(ld_resp_ready),
        .readReg1(readReg1), .readReg2(readReg2), .stall(stall),
        .writeReg(writeReg), .writeData(writeData), .RegWrite(RegWrite),
        .busy(busy), .waw_err(waw_err),
        .fwd1(fwd1), .fwd2(fwd2), .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one rising edge and settle
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_req = 1'b0; ld_rd = '0; ld_resp_valid = 1'b0; ld_resp_data = '0;
        readReg1 = '0; readReg2 = '0;
        tick(); tick();
        RST = 1'b0;
        #1;

        // reset state
        chk("rst_regwrite", 32'(RegWrite), 32'd0);
        chk("rst_writereg", 32'(writeReg), 32'd0);
        chk("rst_writedata", writeData, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_waw", 32'(waw_err), 32'd0);
        chk("rst_ldreq_rdy", 32'(ld_req_ready), 32'd1);
        chk("rst_ldresp_rdy", 32'(ld_resp_ready), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_fwd1_hit", 32'(fwd1_hit), 32'd0);
        chk("rst_fwd2_hit", 32'(fwd2_hit), 32'd0);

        // ALU write, latency 1
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        tick();
        chk("alu_regwrite", 32'(RegWrite), 32'd1);
        chk("alu_writereg", 32'(writeReg), 32'd5);
        chk("alu_writedata", writeData, 32'hDEADBEEF);
        alu_rd = 5'd0; alu_data = 32'h1;
        tick();
        chk("alu_x0_regwrite", 32'(RegWrite), 32'd0);

        // bypass from write port
        alu_rd = 5'd9; alu_data = 32'hCAFE0009;
        tick();
        alu_valid = 1'b0; readReg2 = 5'd9;
        #1;
        chk("byp_fwd2_hit", 32'(fwd2_hit), 32'(BYP));
        chk("byp_fwd2", fwd2, BYP ? 32'hCAFE0009 : 32'd0);
        readReg2 = 5'd0;

        // single load to x7
        ld_req = 1'b1; ld_rd = 5'd7;
        tick();
        ld_req = 1'b0; readReg1 = 5'd7;
        #1;
        chk("ld7_busy", busy, 32'h80);
        chk("ld7_stall", 32'(stall), 32'd1);
        chk("ld7_resp_rdy", 32'(ld_resp_ready), 32'd1);
        ld_resp_valid = 1'b1; ld_resp_data = 32'h1234;
        tick();
        ld_resp_valid = 1'b0;
        chk("ld7_acc_regwrite", 32'(RegWrite), 32'd0);
        chk("ld7_acc_busy", busy, 32'h80);
        chk("ld7_acc_resp_rdy", 32'(ld_resp_ready), 32'd0);
        tick();
        chk("ld7_wr_regwrite", 32'(RegWrite), 32'd1);
        chk("ld7_wr_writereg", 32'(writeReg), 32'd7);
        chk("ld7_wr_writedata", writeData, 32'h1234);
        chk("ld7_wr_busy", busy, 32'd0);
        chk("ld7_wr_stall", 32'(stall), 32'd0);
        readReg1 = 5'd0;

        // fill the tag FIFO, then try a fifth load
        ld_req = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            ld_rd = 5'(i);
            tick();
        end
        chk("full_ldreq_rdy", 32'(ld_req_ready), 32'd0);
        chk("full_busy", busy, 32'h1E);
        ld_rd = 5'd10;
        tick();
        ld_req = 1'b0;
        chk("full_5th_busy", busy, 32'h1E);
        chk("full_5th_rdy", 32'(ld_req_ready), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            ld_resp_valid = 1'b1; ld_resp_data = 32'hA0 + 32'(i);
            tick();
            ld_resp_valid = 1'b0;
            tick();
            chk("order_regwrite", 32'(RegWrite), 32'd1);
            chk("order_writereg", 32'(writeReg), 32'(i));
            chk("order_writedata", writeData, 32'hA0 + 32'(i));
        end
        chk("drained_busy", busy, 32'd0);
        chk("drained_ldreq_rdy", 32'(ld_req_ready), 32'd1);
        chk("drained_resp_rdy", 32'(ld_resp_ready), 32'd0);

        // ALU holds the port for 3 cycles while a load waits in hold
        ld_req = 1'b1; ld_rd = 5'd6;
        tick();
        ld_req = 1'b0;
        ld_resp_valid = 1'b1; ld_resp_data = 32'h66;
        tick();
        ld_resp_valid = 1'b0;
        alu_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu_rd = 5'(11 + i); alu_data = 32'hB0 + 32'(i);
            tick();
            chk("prio_alu_writereg", 32'(writeReg), 32'(11 + i));
            chk("prio_alu_writedata", writeData, 32'hB0 + 32'(i));
            chk("prio_resp_rdy", 32'(ld_resp_ready), 32'd0);
            chk("prio_busy", busy, 32'h40);
        end
        alu_valid = 1'b0;
        tick();
        chk("prio_ld_regwrite", 32'(RegWrite), 32'd1);
        chk("prio_ld_writereg", 32'(writeReg), 32'd6);
        chk("prio_ld_writedata", writeData, 32'h66);
        chk("prio_ld_busy", busy, 32'd0);

        // load to x0 occupies a slot but is discarded on drain
        ld_req = 1'b1; ld_rd = 5'd0;
        tick();
        ld_req = 1'b0;
        chk("x0_busy", busy, 32'd0);
        chk("x0_resp_rdy", 32'(ld_resp_ready), 32'd1);
        ld_resp_valid = 1'b1; ld_resp_data = 32'h77;
        tick();
        ld_resp_valid = 1'b0;
        tick();
        chk("x0_regwrite", 32'(RegWrite), 32'd0);
        chk("x0_resp_rdy_after", 32'(ld_resp_ready), 32'd0);

        // set (push) beats clear (drain) on the same register
        ld_req = 1'b1; ld_rd = 5'd5;
        tick();
        ld_req = 1'b0;
        ld_resp_valid = 1'b1; ld_resp_data = 32'h55;
        tick();
        ld_resp_valid = 1'b0;
        ld_req = 1'b1; ld_rd = 5'd5;
        tick();
        ld_req = 1'b0;
        chk("setwin_writereg", 32'(writeReg), 32'd5);
        chk("setwin_busy", busy, 32'h20);
        ld_resp_valid = 1'b1; ld_resp_data = 32'h56;
        tick();
        ld_resp_valid = 1'b0;
        tick();
        chk("setwin_clear_busy", busy, 32'd0);
        chk("setwin_writedata", writeData, 32'h56);

        // WAW: ALU writes a register with a pending load
        ld_req = 1'b1; ld_rd = 5'd3;
        tick();
        ld_req = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        tick();
        alu_valid = 1'b0;
        chk("waw_err", 32'(waw_err), 32'd1);
        chk("waw_writereg", 32'(writeReg), 32'd3);
        chk("waw_regwrite", 32'(RegWrite), 32'd1);
        chk("waw_busy", busy, 32'h8);
        ld_req = 1'b1; ld_rd = 5'd8;
        tick();
        ld_req = 1'b0;
        tick();
        chk("waw_sticky", 32'(waw_err), 32'd1);
        chk("waw_busy2", busy, 32'h108);

        // reset mid-queue discards pending loads
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        chk("mrst_busy", busy, 32'd0);
        chk("mrst_resp_rdy", 32'(ld_resp_ready), 32'd0);
        chk("mrst_waw", 32'(waw_err), 32'd0);
        chk("mrst_ldreq_rdy", 32'(ld_req_ready), 32'd1);
        ld_resp_valid = 1'b1; ld_resp_data = 32'h99;
        tick();
        tick();
        ld_resp_valid = 1'b0;
        chk("mrst_ignored_regwrite", 32'(RegWrite), 32'd0);
        chk("mrst_ignored_resp_rdy", 32'(ld_resp_ready), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 SHALL have parameter LQ_DEPTH, default 4, number of outstanding loads (power of 2, 2..16).
REQ-002 SHALL have port CLK  input  1  rising-edge clock.
REQ-003 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports alu_valid / alu_rd / alu_data  input  1/5/32  single-cycle ALU result to retire.
REQ-005 SHALL have ports ld_req / ld_rd  input  1/5  load issue, reserving destination ld_rd; ld_req_ready  output  1  load-tag FIFO not full.
REQ-006 SHALL have ports ld_resp_valid / ld_resp_data  input  1/32  in-order load data; ld_resp_ready  output  1  response accepted.
REQ-007 SHALL have ports readReg1 / readReg2  input  5/5  decode source registers; stall  output  1  source has pending load.
REQ-008 SHALL have ports writeReg / writeData / RegWrite  output  5/32/1  registered register-file write port.
REQ-009 SHALL have port busy  output  32  scoreboard, bit n = xn awaiting load data.
REQ-010 SHALL have port waw_err  output  1  sticky: ALU wrote a busy register.
REQ-011 SHALL have ports fwd1 / fwd2  output  32  bypass data, plus fwd1_hit / fwd2_hit  output  1  bypass valid.

Function
REQ-012 SHALL keep a load-tag FIFO of LQ_DEPTH entries holding ld_rd; push on ld_req && ld_req_ready; ld_req_ready = !full, with no same-cycle pop-to-push bypass.
REQ-013 SHALL set busy[ld_rd] on push when ld_rd != 0; ld_rd == 0 still occupies a slot but sets no busy bit.
REQ-014 SHALL drive ld_resp_ready = FIFO not empty && hold register empty; ld_resp_valid with the FIFO empty is ignored.
REQ-015 SHALL, on response accept, pop the FIFO head and load {rd, data} into a one-entry hold register.
REQ-016 SHALL select one write per cycle with priority: ALU (alu_valid) > hold register > none.
REQ-017 SHALL register the selected write: RegWrite/writeReg/writeData appear the cycle after selection, giving ALU latency 1 and load latency minimum 2 from accept.
REQ-018 SHALL suppress RegWrite for rd == 0; a hold entry with rd 0 is drained and discarded silently.
REQ-019 SHALL empty the hold register when its write is selected, and clear busy[rd] in that same edge.
REQ-020 SHALL let a same-register set (push) win over a clear (drain) in the same cycle.
REQ-021 SHALL stall the hold register indefinitely while alu_valid is held, with ld_resp_ready low throughout.
REQ-022 SHALL drive stall = (readReg1 != 0 && busy[readReg1]) || (readReg2 != 0 && busy[readReg2]), combinationally.
REQ-023 SHALL set waw_err when alu_valid with alu_rd != 0 && busy[alu_rd]; the write still proceeds and busy is unchanged; cleared only by reset.

Reset
REQ-024 SHALL, with RST high at a CLK edge, empty the FIFO and hold register and clear busy, waw_err, RegWrite, writeReg and writeData to 0.
REQ-025 SHALL, after reset, present ld_req_ready = 1, ld_resp_ready = 0, stall = 0, and fwd*_hit = 0.
REQ-026 SHALL make reset mid-operation discard all pending loads; responses arriving afterwards with the FIFO empty are ignored.

Configuration
REQ-027 SHALL, with WB_BYPASS_EN defined, drive fwdN_hit = RegWrite && writeReg == readRegN && writeReg != 0, and fwdN = writeData, combinationally.
REQ-028 SHALL, without WB_BYPASS_EN, tie fwd1, fwd2, fwd1_hit and fwd2_hit to 0; all other behaviour is identical.

Verification
REQ-029 SHALL cover: alu_valid, alu_rd=5, alu_data=0xDEADBEEF -> next cycle RegWrite=1, writeReg=5, writeData=0xDEADBEEF; alu_rd=0 -> RegWrite=0.
REQ-030 SHALL cover: ld_req rd=7, then readReg1=7 -> stall=1, busy[7]=1; response 0x1234 accepted -> two cycles later a write to x7 = 0x1234, busy[7]=0, stall=0.
REQ-031 SHALL cover: 4 ld_req with LQ_DEPTH=4 -> ld_req_ready=0; a 5th ld_req is not pushed; responses retire in issue order.
REQ-032 SHALL cover: hold full with alu_valid held 3 cycles -> ALU writes for 3 cycles, ld_resp_ready=0, and the load writes on the 4th cycle.
REQ-033 SHALL cover: ld_req rd=3 then ALU write rd=3 -> waw_err=1 and stays 1 until RST; RST mid-queue -> busy=0, ld_resp_ready=0.
REQ-034 SHALL cover, with WB_BYPASS_EN: RegWrite to x9 with readReg2=9 -> fwd2_hit=1 and fwd2=writeData; without the macro -> fwd2_hit=0.
